// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// data-memory freeze with timeout trap, and saturating stall/flush statistics.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_addr_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             id_ex_hold_o,
    output logic             ex_mem_hold_o,
    output logic             mem_wb_bubble_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    function automatic logic load_use(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return memread & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
    endfunction

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic lu_s, miss_s;
    logic pc_write_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s;
    logic id_ex_hold_s, ex_mem_hold_s, mem_wb_bubble_s, timeout_s;

    assign lu_s   = load_use(ex_memread_i, ex_rt_addr_i, id_rs_addr_i, id_rt_addr_i, id_uses_rt_i);
    assign miss_s = mem_req_i & ~dmem_ack_i;

    // Next-state and pre-reset control outputs
    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        id_ex_hold_s    = 1'b0;
        ex_mem_hold_s   = 1'b0;
        mem_wb_bubble_s = 1'b0;
        timeout_s       = 1'b0;
        case (state_q)
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = ST_RUN;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    pc_write_s      = 1'b0;
                    if_id_write_s   = 1'b0;
                    id_ex_hold_s    = 1'b1;
                    ex_mem_hold_s   = 1'b1;
                    mem_wb_bubble_s = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                end
            end
            ST_ERR: begin
                pc_write_s      = 1'b0;
                if_id_write_s   = 1'b0;
                id_ex_bubble_s  = 1'b1;
                id_ex_hold_s    = 1'b1;
                ex_mem_hold_s   = 1'b1;
                mem_wb_bubble_s = 1'b1;
                timeout_s       = 1'b1;
            end
            default: begin
                // RUN, and the unused encoding which recovers into RUN
                state_d = ST_RUN;
                if (miss_s) begin
                    pc_write_s      = 1'b0;
                    if_id_write_s   = 1'b0;
                    id_ex_hold_s    = 1'b1;
                    ex_mem_hold_s   = 1'b1;
                    mem_wb_bubble_s = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = {WAIT_W{1'b0}};
                    end else begin
                        wait_d  = {WAIT_W{1'b0}};
                    end
                end else if (lu_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                end else if (id_branch_taken_i) begin
                    if_id_flush_s  = 1'b1;
                end else begin
                    if_id_flush_s  = 1'b0;
                end
            end
        endcase
    end

    // Saturating statistics counters; ERR cycles are not counted as stalls
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write_s && (state_q != ST_ERR) && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (if_id_flush_s && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_ONE;
        end else begin
            flush_d = flush_q;
        end
    end

    // State, wait timer and counters with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= {WAIT_W{1'b0}};
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // While reset is asserted the pipe is held with bubbles regardless of state
    always_comb begin
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b1;
        id_ex_hold_o    = 1'b0;
        ex_mem_hold_o   = 1'b0;
        mem_wb_bubble_o = 1'b1;
        state_o         = 2'd0;
        timeout_o       = 1'b0;
        stall_cnt_o     = {CNT_W{1'b0}};
        flush_cnt_o     = {CNT_W{1'b0}};
        if (rst_i) begin
            pc_write_o      = pc_write_s;
            if_id_write_o   = if_id_write_s;
            if_id_flush_o   = if_id_flush_s;
            id_ex_bubble_o  = id_ex_bubble_s;
            id_ex_hold_o    = id_ex_hold_s;
            ex_mem_hold_o   = ex_mem_hold_s;
            mem_wb_bubble_o = mem_wb_bubble_s;
            state_o         = state_q;
            timeout_o       = timeout_s;
            stall_cnt_o     = stall_q;
            flush_cnt_o     = flush_q;
        end else begin
            state_o         = 2'd0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with small counters and a short memory timeout.
module tb_hazard_stall_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold, mem_wb_bubble}
    localparam logic [6:0] C_NORM   = 7'b1100000;
    localparam logic [6:0] C_FREEZE = 7'b0000111;
    localparam logic [6:0] C_LU     = 7'b0001000;
    localparam logic [6:0] C_BR     = 7'b1110000;
    localparam logic [6:0] C_ERR    = 7'b0001111;
    localparam logic [6:0] C_RST    = 7'b0001001;

    typedef struct packed {
        logic [6:0] ctl;
        logic [1:0] st;
        logic       to;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs_addr_i, id_rt_addr_i, ex_rt_addr_i;
    logic             id_uses_rt_i, ex_memread_i, id_branch_taken_i, mem_req_i, dmem_ack_i;
    logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
    logic             id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o, timeout_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_sc = 4'd0;
    logic [3:0] m_fc = 4'd0;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs_addr_i      (id_rs_addr_i),
        .id_rt_addr_i      (id_rt_addr_i),
        .id_uses_rt_i      (id_uses_rt_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rt_addr_i      (ex_rt_addr_i),
        .id_branch_taken_i (id_branch_taken_i),
        .mem_req_i         (mem_req_i),
        .dmem_ack_i        (dmem_ack_i),
        .pc_write_o        (pc_write_o),
        .if_id_write_o     (if_id_write_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_bubble_o    (id_ex_bubble_o),
        .id_ex_hold_o      (id_ex_hold_o),
        .ex_mem_hold_o     (ex_mem_hold_o),
        .mem_wb_bubble_o   (mem_wb_bubble_o),
        .state_o           (state_o),
        .timeout_o         (timeout_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, compare at the falling edge
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] exrt, input logic br,
                        input logic mq, input logic ack,
                        input logic [6:0] ctl, input logic [1:0] st);
        exp_t e;
        rst_i = rst; id_rs_addr_i = rs; id_rt_addr_i = rt; id_uses_rt_i = uses;
        ex_memread_i = mr; ex_rt_addr_i = exrt; id_branch_taken_i = br;
        mem_req_i = mq; dmem_ack_i = ack;
        e.ctl = ctl;
        e.st  = st;
        e.to  = (st == 2'd2);
        e.sc  = rst ? m_sc : 4'd0;
        e.fc  = rst ? m_fc : 4'd0;
        sb_q.push_back(e);
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".ctl"}, 32'({pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
                                    id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o}), 32'(e.ctl));
            chk({tag, ".state"}, 32'(state_o), 32'(e.st));
            chk({tag, ".timeout"}, 32'(timeout_o), 32'(e.to));
            chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(e.sc));
            chk({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(e.fc));
        end
        if (!rst) begin
            m_sc = 4'd0;
            m_fc = 4'd0;
        end else if (st != 2'd2) begin
            if (!ctl[6] && m_sc != 4'hF) m_sc = m_sc + 4'd1;
            if (ctl[4] && m_fc != 4'hF) m_fc = m_fc + 4'd1;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with garbage inputs, then release
        step("rst_a", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_RST, 2'd0);
        step("rst_b", 1'b0, 5'd9, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, C_RST, 2'd0);
        step("rel",   1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);

        // Load-use on RS, on RT, and the r0 / unused-RT exemptions
        step("lu_rs",   1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,   2'd0);
        step("lu_post", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);
        step("lu_r0",   1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);
        step("lu_rt",   1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU,   2'd0);
        step("lu_nort", 1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);

        // Stall beats branch, then the branch flushes
        step("lu_br",  1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_LU,   2'd0);
        step("br",     1'b1, 5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_BR,   2'd0);
        step("br_cnt", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM, 2'd0);

        // Memory wait: 3 frozen cycles, acked cycle ignores a pending load-use
        step("mw_rst",  1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST,    2'd0);
        step("mw_miss", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_FREEZE, 2'd0);
        step("mw_w0",   1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_FREEZE, 2'd1);
        step("mw_w1",   1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd1);
        step("mw_ack",  1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_NORM,   2'd1);
        step("mw_lu",   1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,     2'd0);
        step("mw_done", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM,   2'd0);

        // Timeout into sticky ERR, then reset recovers
        step("to_rst",  1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST,    2'd0);
        step("to_miss", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step($sformatf("to_w%0d", i), 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
                 C_FREEZE, 2'd1);
        end
        for (int i = 0; i < 20; i++) begin
            step($sformatf("err%0d", i), 1'b1, 5'($urandom), 5'($urandom), 1'($urandom),
                 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 C_ERR, 2'd2);
        end
        step("err_rst", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST,  2'd0);
        step("err_run", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), 1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0,
                 C_LU, 2'd0);
        end
        step("sat_idle", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0);
        chk("sat_final", 32'(stall_cnt_o), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
